usb_reg_bus_master: RTL and testbench
=====================================

// Module: usb_reg_bus_master
// PURPOSE
//   Initiator for the 8-bit strobe/ack register bus that usbSlave exposes (address, data, we, strobe, ack).
//   Turns single or burst commands into bus cycles and streams write/read data over valid/ready.
//   Sits between a host-side controller (CPU bridge, test sequencer) and the USB slave register port.
//   Supports fixed-address bursts for endpoint FIFO data registers and incrementing bursts for register blocks.
// PARAMETERS
//   LEN_W    8    width of cmd_len_i; a burst is cmd_len_i+1 transfers (1..2^LEN_W)
//   TIMEOUT  64   clocks to wait for ack_i per transfer before aborting; 0 = never time out
//   TO_W     8    width of the timeout counter; must hold TIMEOUT-1
// PORTS
//   clk_i         in   1      single clock for all logic
//   rst_i         in   1      reset: synchronous, active-low
//   cmd_valid_i   in   1      command valid
//   cmd_ready_o   out  1      command accepted when valid & ready
//   cmd_we_i      in   1      1 = write burst, 0 = read burst
//   cmd_addr_i    in   8      start address
//   cmd_inc_i     in   1      1 = address +1 per transfer, 0 = fixed address
//   cmd_len_i     in   LEN_W  transfers minus one
//   wr_valid_i    in   1      write data valid
//   wr_ready_o    out  1      write data accepted when valid & ready
//   wr_data_i     in   8      write data byte
//   rd_valid_o    out  1      read data valid
//   rd_ready_i    in   1      read data consumed when valid & ready
//   rd_data_o     out  8      read data byte
//   adr_o         out  8      bus address
//   dat_o         out  8      bus write data
//   dat_i         in   8      bus read data, sampled with ack_i
//   we_o          out  1      bus write enable
//   stb_o         out  1      bus strobe
//   ack_i         in   1      bus acknowledge; counts only while stb_o=1
//   busy_o        out  1      1 in any state except IDLE
//   done_o        out  1      one-cycle pulse at end of every command, including aborted ones
//   err_o         out  1      one-cycle pulse with done_o when the command aborts on timeout
// BEHAVIOUR
//   Reset (rst_i=0 at a clock edge): state=IDLE; stb_o, we_o, rd_valid_o, done_o, err_o, busy_o = 0.
//   Reset also clears adr_o, dat_o and rd_data_o to 0x00. Any burst in progress is abandoned with no done_o.
//   cmd_ready_o=1 only in IDLE. wr_ready_o=1 only in WDATA.
//   States and transitions:
//     IDLE  : cmd handshake latches we/addr/inc/len into adr_o/we_o/count; go to WDATA (write) or BUS (read).
//     WDATA : wr handshake loads dat_o; stb_o<=1; go to BUS.
//     BUS   : stb_o=1; adr_o/dat_o/we_o stay stable; timer counts up from 0 each clock.
//       ack_i=1, read  : rd_data_o<=dat_i, rd_valid_o<=1, stb_o<=0; go to RDOUT.
//       ack_i=1, write : stb_o<=0; go to DONE if count==0, else count-1, adr+=inc, go to WDATA.
//       No ack and timer==TIMEOUT-1 (TIMEOUT!=0): stb_o<=0; go to DONE with err flagged.
//         Remaining transfers are dropped; no rd_valid_o is raised for the aborted transfer.
//     RDOUT : hold rd_valid_o/rd_data_o until rd_ready_i.
//       On the rd handshake: rd_valid_o<=0; go to DONE if count==0, else count-1, adr+=inc, stb_o<=1, go to BUS.
//     DONE  : done_o=1 (err_o=1 if aborted) for exactly one cycle; go to IDLE.
//   Timing:
//     Read: cmd accepted at cycle N -> stb_o high at N+1.
//     Write: cmd accepted at N -> wr_ready_o high at N+1; wr accepted at W -> stb_o high at W+1.
//     ack_i at cycle M -> stb_o low at M+1. stb_o is therefore low for at least one cycle between transfers.
//       Read: rd_valid_o high at M+1. Last transfer: done_o at M+1 (write) or the cycle after the final rd handshake (read).
//     ack_i seen in the same cycle stb_o is first high completes the transfer; zero-wait-state slaves are legal.
//   Width rules:
//     adr_o increments modulo 256 (0xFF -> 0x00). The timer is TO_W bits and resets at the start of every transfer.
//     count is LEN_W bits; cmd_len_i all-ones = 2^LEN_W transfers.
//   Stray signals: ack_i while stb_o=0 is ignored. rd_ready_i outside RDOUT and wr_valid_i outside WDATA have no effect.
// TESTING
//   Single write: addr 0x04, data 0x5A, len 0; ack after 2 wait cycles
//     -> stb_o for 3 cycles, adr_o=0x04, dat_o=0x5A, we_o=1; one done_o, err_o=0.
//   Fixed read burst: addr 0x20, inc=0, len 3; slave returns 0x11,0x22,0x33,0x44
//     -> adr_o=0x20 on all four; rd_data_o sequence matches; done_o once.
//   Incrementing write with wrap: addr 0xFE, len 3, inc=1
//     -> adr_o sequence 0xFE,0xFF,0x00,0x01.
//   Backpressure: rd_ready_i held 0 for 5 cycles
//     -> rd_valid_o and rd_data_o stable; stb_o stays 0; next transfer starts after the handshake.
//   Timeout: TIMEOUT=8, never ack
//     -> stb_o high exactly 8 cycles; done_o+err_o pulse together; no rd_valid_o; cmd_ready_o high next cycle.
//   Reset mid-burst: rst_i=0 during BUS of transfer 2/4
//     -> next cycle stb_o=0, busy_o=0, no done_o; a new command then runs normally.

Source files
------------

// File: rtl/usb_reg_bus_master.sv
// Initiator for an 8-bit strobe/ack register bus. It turns single or burst commands
// into bus cycles and streams the write and read data over valid/ready handshakes.
module usb_reg_bus_master #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [7:0]       cmd_addr_i,
    input  logic             cmd_inc_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [7:0]       wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [7:0]       rd_data_o,
    output logic [7:0]       adr_o,
    output logic [7:0]       dat_o,
    input  logic [7:0]       dat_i,
    output logic             we_o,
    output logic             stb_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_BUS,
        S_RDOUT,
        S_DONE
    } state_t;

    // With TIMEOUT=0 the compare value is irrelevant; the enable below keeps it unused.
    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TIMER_EN   = (TIMEOUT != 0);

    state_t           state_q;
    logic [7:0]       adr_q;
    logic [7:0]       dat_q;
    logic [7:0]       rd_data_q;
    logic             we_q;
    logic             inc_q;
    logic             stb_q;
    logic             rd_valid_q;
    logic             done_q;
    logic             err_q;
    logic [LEN_W-1:0] count_q;
    logic [TO_W-1:0]  timer_q;

    logic [7:0]       adr_d;
    logic             timer_expired;
    logic             last_xfer;

    assign adr_d         = adr_q + {7'd0, inc_q};
    assign timer_expired = TIMER_EN && (timer_q == TIMER_LAST);
    assign last_xfer     = (count_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            adr_q      <= 8'h00;
            dat_q      <= 8'h00;
            rd_data_q  <= 8'h00;
            we_q       <= 1'b0;
            inc_q      <= 1'b0;
            stb_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            timer_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        adr_q   <= cmd_addr_i;
                        we_q    <= cmd_we_i;
                        inc_q   <= cmd_inc_i;
                        count_q <= cmd_len_i;
                        timer_q <= '0;
                        if (cmd_we_i) begin
                            state_q <= S_WDATA;
                        end else begin
                            stb_q   <= 1'b1;
                            state_q <= S_BUS;
                        end
                    end
                end
                S_WDATA: begin
                    if (wr_valid_i) begin
                        dat_q   <= wr_data_i;
                        stb_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    // An ack in the first strobe cycle is valid: zero-wait-state slaves.
                    if (ack_i) begin
                        stb_q <= 1'b0;
                        if (!we_q) begin
                            rd_data_q  <= dat_i;
                            rd_valid_q <= 1'b1;
                            state_q    <= S_RDOUT;
                        end else if (last_xfer) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            count_q <= count_q - 1'b1;
                            adr_q   <= adr_d;
                            state_q <= S_WDATA;
                        end
                    end else if (timer_expired) begin
                        // Abort drops every remaining transfer of the burst.
                        stb_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RDOUT: begin
                    if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        if (last_xfer) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            count_q <= count_q - 1'b1;
                            adr_q   <= adr_d;
                            stb_q   <= 1'b1;
                            timer_q <= '0;
                            state_q <= S_BUS;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WDATA);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign we_o        = we_q;
    assign stb_o       = stb_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_usb_reg_bus_master.sv
// Scoreboard bench for usb_reg_bus_master: a wait-state slave, write source and read sink
// drive the DUT while a negedge monitor pops expected bus cycles, read bytes and done pulses.
module tb_usb_reg_bus_master;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [7:0]       cmd_addr_i;
    logic             cmd_inc_i;
    logic [LEN_W-1:0] cmd_len_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic [7:0]       wr_data_i;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [7:0]       rd_data_o;
    logic [7:0]       adr_o;
    logic [7:0]       dat_o;
    logic [7:0]       dat_i;
    logic             we_o;
    logic             stb_o;
    logic             ack_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    always #5 clk = ~clk;

    usb_reg_bus_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_inc_i(cmd_inc_i), .cmd_len_i(cmd_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .stb_o(stb_o),
        .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        logic [7:0] adr;
        logic       we;
        logic [7:0] dat;
        int         len;
        bit         acked;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [7:0] rd_exp_q[$];
    bit         done_exp_q[$];
    logic [7:0] slave_dat_q[$];
    logic [7:0] wr_src_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Slave, write source and read sink all act 2 time units after the rising edge.
    int slave_waits = 0;
    bit slave_noack = 0;
    bit stray       = 0;
    int rd_hold     = 0;
    int s_cnt       = 0;
    int h_cnt       = 0;

    always begin
        @(posedge clk);
        #2;
        if (stb_o) begin
            if (!slave_noack && s_cnt == slave_waits) begin
                ack_i = 1'b1;
                if (!we_o && slave_dat_q.size() > 0) dat_i = slave_dat_q.pop_front();
                else dat_i = 8'($urandom);
            end else begin
                ack_i = 1'b0;
                dat_i = 8'($urandom);
            end
            s_cnt++;
        end else begin
            s_cnt = 0;
            ack_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            dat_i = 8'($urandom);
        end
        if (rd_valid_o) begin
            if (h_cnt < rd_hold) begin
                rd_ready_i = 1'b0;
                h_cnt++;
            end else begin
                rd_ready_i = 1'b1;
            end
        end else begin
            h_cnt      = 0;
            rd_ready_i = stray ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        wr_valid_i = (wr_src_q.size() > 0);
        wr_data_i  = (wr_src_q.size() > 0) ? wr_src_q[0] : 8'($urandom);
    end

    int         run = 0;
    logic [7:0] f_adr;
    logic [7:0] f_dat;
    logic       f_we;
    bit         f_ack;
    bit         unstable;
    bit         after_done = 0;
    int         done_seen  = 0;
    logic [7:0] tmp8;
    bus_exp_t   e;

    always @(negedge clk) begin
        if (stb_o) begin
            if (run == 0) begin
                f_adr = adr_o; f_we = we_o; f_dat = dat_o; f_ack = 0; unstable = 0;
            end else if (adr_o !== f_adr || we_o !== f_we || dat_o !== f_dat) begin
                unstable = 1;
            end
            run++;
            if (ack_i) f_ack = 1;
        end else if (run > 0) begin
            $display("BUS adr=%02h we=%0b dat=%02h cycles=%0d acked=%0b", f_adr, f_we, f_dat, run, f_ack);
            if (bus_q.size() == 0) begin
                check_eq("bus_unexp", 32'(run), 32'd0);
            end else begin
                e = bus_q.pop_front();
                check_eq("bus_adr", 32'(f_adr), 32'(e.adr));
                check_eq("bus_we", 32'(f_we), 32'(e.we));
                if (e.we) check_eq("bus_dat", 32'(f_dat), 32'(e.dat));
                check_eq("stb_cycles", 32'(run), 32'(e.len));
                check_eq("bus_acked", 32'(f_ack), 32'(e.acked));
                check_eq("bus_stable", 32'(unstable), 32'd0);
            end
            run = 0;
        end

        if (rd_valid_o) begin
            if (rd_exp_q.size() == 0) begin
                check_eq("rd_unexp", 32'(rd_valid_o), 32'd0);
            end else if (rd_ready_i) begin
                $display("RD  data=%02h exp=%02h", rd_data_o, rd_exp_q[0]);
                check_eq("rd_data", 32'(rd_data_o), 32'(rd_exp_q.pop_front()));
            end else begin
                check_eq("bp_stb", 32'(stb_o), 32'd0);
                check_eq("bp_data", 32'(rd_data_o), 32'(rd_exp_q[0]));
            end
        end

        if (wr_valid_i && wr_ready_o && wr_src_q.size() > 0) tmp8 = wr_src_q.pop_front();

        if (after_done) begin
            check_eq("rdy_after_done", 32'(cmd_ready_o), 32'd1);
            check_eq("done_width", 32'(done_o), 32'd0);
            after_done = 0;
        end else if (done_o) begin
            $display("DONE err=%0b", err_o);
            if (done_exp_q.size() == 0) check_eq("done_unexp", 32'(done_o), 32'd0);
            else check_eq("done_err", 32'(err_o), 32'(done_exp_q.pop_front()));
            check_eq("busy_in_done", 32'(busy_o), 32'd1);
            done_seen++;
            after_done = 1;
        end else if (err_o) begin
            check_eq("err_no_done", 32'(err_o), 32'(done_o));
        end
    end

    task automatic exp_write(input logic [7:0] addr, input bit inc, input int len, input logic [7:0] base);
        bus_exp_t x;
        for (int i = 0; i <= len; i++) begin
            x.adr   = 8'(addr + (inc ? i : 0));
            x.we    = 1'b1;
            x.dat   = 8'(base + i);
            x.len   = slave_waits + 1;
            x.acked = 1;
            wr_src_q.push_back(x.dat);
            bus_q.push_back(x);
        end
        done_exp_q.push_back(1'b0);
    endtask

    task automatic exp_read(input logic [7:0] addr, input bit inc, input int len,
                            input logic [7:0] base, input logic [7:0] step);
        bus_exp_t x;
        logic [7:0] d;
        for (int i = 0; i <= len; i++) begin
            d       = 8'(base + i * step);
            x.adr   = 8'(addr + (inc ? i : 0));
            x.we    = 1'b0;
            x.dat   = 8'h00;
            x.len   = slave_waits + 1;
            x.acked = 1;
            bus_q.push_back(x);
            slave_dat_q.push_back(d);
            rd_exp_q.push_back(d);
        end
        done_exp_q.push_back(1'b0);
    endtask

    task automatic send_cmd(input bit we, input logic [7:0] addr, input bit inc, input int len);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_inc_i   = inc;
        cmd_len_i   = LEN_W'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready_o) break;
        end
        check_eq("cmd_accept", 32'(cmd_ready_o), 32'd1);
        @(posedge clk);
        #2;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_seen;
        for (int i = 0; i < budget && done_seen == start; i++) @(posedge clk);
        check_eq("wait_done", 32'(done_seen != start), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_exp_t x;
        rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 8'h00;
        cmd_inc_i = 1'b0; cmd_len_i = '0; wr_valid_i = 1'b0; wr_data_i = 8'h00;
        rd_ready_i = 1'b1; dat_i = 8'h00; ack_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stb", 32'(stb_o), 32'd0);
        check_eq("rst_we", 32'(we_o), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_adr", 32'(adr_o), 32'd0);
        check_eq("rst_dat", 32'(dat_o), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data_o), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check_eq("rst_wr_ready", 32'(wr_ready_o), 32'd0);
        @(posedge clk);
        #2;
        rst_i = 1'b1;

        // Single write, two wait states.
        slave_waits = 2;
        exp_write(8'h04, 1'b0, 0, 8'h5A);
        send_cmd(1'b1, 8'h04, 1'b0, 0);
        wait_done(200);

        // Fixed-address read burst.
        slave_waits = 1;
        exp_read(8'h20, 1'b0, 3, 8'h11, 8'h11);
        send_cmd(1'b0, 8'h20, 1'b0, 3);
        wait_done(400);

        // Incrementing write wrapping through 0xFF, zero wait states, stray acks.
        slave_waits = 0; stray = 1;
        exp_write(8'hFE, 1'b1, 3, 8'hA0);
        send_cmd(1'b1, 8'hFE, 1'b1, 3);
        wait_done(400);

        // Read backpressure.
        rd_hold = 5;
        exp_read(8'h80, 1'b1, 1, 8'h5C, 8'h01);
        send_cmd(1'b0, 8'h80, 1'b1, 1);
        wait_done(400);
        rd_hold = 0; stray = 0;

        // Timeout: slave never acks.
        slave_noack = 1;
        x.adr = 8'h30; x.we = 1'b0; x.dat = 8'h00; x.len = TIMEOUT; x.acked = 0;
        bus_q.push_back(x);
        done_exp_q.push_back(1'b1);
        send_cmd(1'b0, 8'h30, 1'b1, 2);
        wait_done(200);
        slave_noack = 0;

        // Reset while transfer 2 of 4 is on the bus.
        slave_waits = 1;
        x.adr = 8'h40; x.we = 1'b0; x.len = 2; x.acked = 1;
        bus_q.push_back(x);
        slave_dat_q.push_back(8'h3C);
        rd_exp_q.push_back(8'h3C);
        x.adr = 8'h41; x.len = 1; x.acked = 0;
        bus_q.push_back(x);
        send_cmd(1'b0, 8'h40, 1'b1, 3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_valid_o) break;
        end
        slave_noack = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stb_o) break;
        end
        check_eq("rst_reach_bus", 32'(stb_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_stb", 32'(stb_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_rd_data", 32'(rd_data_o), 32'd0);
        rst_i = 1'b1;
        slave_noack = 0;
        repeat (5) @(posedge clk);
        #2;

        // Random commands after reset.
        for (int n = 0; n < 4; n++) begin
            bit         we;
            bit         inc;
            logic [7:0] addr;
            int         len;
            we          = 1'($urandom_range(0, 1));
            inc         = 1'($urandom_range(0, 1));
            addr        = 8'($urandom);
            len         = $urandom_range(0, 3);
            slave_waits = $urandom_range(0, 3);
            if (we) exp_write(addr, inc, len, 8'($urandom));
            else exp_read(addr, inc, len, 8'($urandom), 8'h07);
            send_cmd(we, addr, inc, len);
            wait_done(500);
        end

        repeat (3) @(posedge clk);
        check_eq("bus_q_left", 32'(bus_q.size()), 32'd0);
        check_eq("rd_q_left", 32'(rd_exp_q.size()), 32'd0);
        check_eq("done_q_left", 32'(done_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
